// File: rtl/conv_cmd_ctrl.sv
// Byte-stream command controller: streams payloads into NUM_MEM memories and starts/awaits NUM_CONV layers.
// Define CONV_CTRL_TIMEOUT_EN to abort stalled write commands after TIMEOUT_CYC idle cycles.
//
// state         | meaning
// --------------+-----------------------------------------------------------
// ST_OP         | idle, waiting for an opcode byte
// ST_SEL        | waiting for the memory select byte
// ST_LEN_L      | waiting for payload length, low byte
// ST_LEN_H      | waiting for payload length, high byte; length is validated
// ST_DATA       | streaming payload bytes to the selected memory
// ST_CONV_START | start pulse on the selected layer is visible
// ST_CONV_WAIT  | waiting for the selected layer's done
module conv_cmd_ctrl #(
  parameter int unsigned NUM_MEM      = 7,
  parameter int unsigned NUM_CONV     = 3,
  parameter int unsigned ADDR_W       = 16,
  parameter logic [7:0]  OP_WRITE     = 8'h19,
  parameter logic [7:0]  OP_CONV_BASE = 8'h20,
  parameter int unsigned TIMEOUT_CYC  = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  output logic [NUM_MEM-1:0]  mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [7:0]          mem_data,
  output logic [NUM_CONV-1:0] conv_start,
  input  logic [NUM_CONV-1:0] conv_done,
  output logic                busy,
  output logic                err,
  output logic [1:0]          err_code,
  output logic [ADDR_W:0]     bytes_written
);

  localparam int SEL_W = (NUM_MEM > 1) ? $clog2(NUM_MEM) : 1;
  localparam int LAY_W = (NUM_CONV > 1) ? $clog2(NUM_CONV) : 1;
  localparam logic [16:0]   MAX_LEN = 17'(1) << ADDR_W;
  localparam logic [ADDR_W:0] BW_ONE = 1;

  typedef enum logic [2:0] {
    ST_OP, ST_SEL, ST_LEN_L, ST_LEN_H, ST_DATA, ST_CONV_START, ST_CONV_WAIT
  } state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [15:0]         len_q, len_d;
  logic [LAY_W-1:0]    layer_q, layer_d;
  logic [ADDR_W:0]     bw_q, bw_d;
  logic [NUM_MEM-1:0]  mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_data_q, mem_data_d;
  logic [NUM_CONV-1:0] conv_start_q, conv_start_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;

`ifdef CONV_CTRL_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_ONE = 1;
  logic [IDLE_W-1:0] idle_q, idle_d;
`endif

  logic             accept;
  logic [7:0]       conv_idx;
  logic             conv_hit;
  logic [LAY_W-1:0] conv_layer;
  logic [16:0]      len_full;
  logic [ADDR_W:0]  bw_next;

  assign accept     = in_valid && in_ready_q;
  assign conv_idx   = in_data - OP_CONV_BASE;
  assign conv_hit   = (conv_idx >= 8'd1) && (32'(conv_idx) <= NUM_CONV);
  assign conv_layer = LAY_W'(conv_idx - 8'd1);
  assign len_full   = {1'b0, in_data, len_q[7:0]};
  assign bw_next    = bw_q + BW_ONE;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    len_d        = len_q;
    layer_d      = layer_q;
    bw_d         = bw_q;
    mem_we_d     = '0;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    conv_start_d = '0;
    err_d        = err_q;
    err_code_d   = err_code_q;
    case (state_q)
      ST_OP: if (accept) begin
        if (in_data == OP_WRITE) begin
          state_d = ST_SEL;
        end else if (conv_hit) begin
          state_d                  = ST_CONV_START;
          layer_d                  = conv_layer;
          conv_start_d[conv_layer] = 1'b1;
        end else begin
          err_d      = 1'b1;
          err_code_d = 2'd1;
        end
      end
      ST_SEL: if (accept) begin
        if (32'(in_data) < NUM_MEM) begin
          sel_d   = in_data[SEL_W-1:0];
          state_d = ST_LEN_L;
        end else begin
          err_d      = 1'b1;
          err_code_d = 2'd2;
          state_d    = ST_OP;
        end
      end
      ST_LEN_L: if (accept) begin
        len_d[7:0] = in_data;
        state_d    = ST_LEN_H;
      end
      ST_LEN_H: if (accept) begin
        len_d[15:8] = in_data;
        if (len_full == 17'd0) begin
          bw_d    = '0;
          state_d = ST_OP;
        end else if (len_full > MAX_LEN) begin
          err_d      = 1'b1;
          err_code_d = 2'd3;
          state_d    = ST_OP;
        end else begin
          bw_d    = '0;
          state_d = ST_DATA;
        end
      end
      // bw_q doubles as the write address; the length check keeps it inside ADDR_W bits
      ST_DATA: if (accept) begin
        mem_we_d[sel_q] = 1'b1;
        mem_addr_d      = bw_q[ADDR_W-1:0];
        mem_data_d      = in_data;
        bw_d            = bw_next;
        if (17'(bw_next) == {1'b0, len_q}) state_d = ST_OP;
      end
      ST_CONV_START: state_d = ST_CONV_WAIT;
      ST_CONV_WAIT:  if (conv_done[layer_q]) state_d = ST_OP;
      default:       state_d = ST_OP;
    endcase

`ifdef CONV_CTRL_TIMEOUT_EN
    idle_d = '0;
    if (!accept && (state_q inside {ST_SEL, ST_LEN_L, ST_LEN_H, ST_DATA})) begin
      idle_d = idle_q + IDLE_ONE;
      if (32'(idle_d) >= TIMEOUT_CYC) begin
        idle_d     = '0;
        state_d    = ST_OP;
        err_d      = 1'b1;
        err_code_d = 2'd3;
      end
    end
`endif

    in_ready_d = !(state_d inside {ST_CONV_START, ST_CONV_WAIT});
    busy_d     = (state_d != ST_OP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_OP;
      sel_q        <= '0;
      len_q        <= '0;
      layer_q      <= '0;
      bw_q         <= '0;
      mem_we_q     <= '0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      conv_start_q <= '0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= '0;
`ifdef CONV_CTRL_TIMEOUT_EN
      idle_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      len_q        <= len_d;
      layer_q      <= layer_d;
      bw_q         <= bw_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      conv_start_q <= conv_start_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
`ifdef CONV_CTRL_TIMEOUT_EN
      idle_q       <= idle_d;
`endif
    end
  end

  assign in_ready      = in_ready_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_data      = mem_data_q;
  assign conv_start    = conv_start_q;
  assign busy          = busy_q;
  assign err           = err_q;
  assign err_code      = err_code_q;
  assign bytes_written = bw_q;

endmodule

// File: tb/tb_conv_cmd_ctrl.sv
// Self-checking bench for conv_cmd_ctrl (ADDR_W=4, TIMEOUT_CYC=8): vector table, directed corners, random commands.
module tb_conv_cmd_ctrl;
  localparam int NM = 7, NC = 3, AW = 4, TO = 8;

  logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic [NC-1:0] conv_done = '0;
  logic in_ready, busy, err;
  logic [NM-1:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0] mem_data;
  logic [NC-1:0] conv_start;
  logic [1:0] err_code;
  logic [AW:0] bytes_written;
  int checks = 0, failures = 0, cyc = 0;

  conv_cmd_ctrl #(.NUM_MEM(NM), .NUM_CONV(NC), .ADDR_W(AW), .OP_WRITE(8'h19),
                  .OP_CONV_BASE(8'h20), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .conv_start(conv_start),
    .conv_done(conv_done), .busy(busy), .err(err), .err_code(err_code),
    .bytes_written(bytes_written));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [NM-1:0] we; logic [AW-1:0] addr; logic [7:0] data; int cyc; } strobe_t;
  strobe_t sq[$], exp_sq[$];
  logic [NC-1:0] cq[$];

  always @(negedge clk) begin
    if (mem_we != '0) sq.push_back('{we: mem_we, addr: mem_addr, data: mem_data, cyc: cyc});
    if (conv_start != '0) cq.push_back(conv_start);
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, required finish before 500000ns");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // mode 0: valid every cycle, 1: random valid (never more than 3 idle in a row), 2: one idle cycle first
  task automatic send(input logic [7:0] b, input int mode);
    int miss = 0;
    bit acc;
    if (mode == 2) begin in_valid = 1'b0; tick(); end
    for (int t = 0; t < 64; t++) begin
      in_data = b;
      if (mode == 1 && miss < 3) in_valid = ($urandom_range(0, 1) == 1);
      else in_valid = 1'b1;
      acc = in_valid && in_ready;
      tick();
      if (acc) begin in_valid = 1'b0; return; end
      miss = in_valid ? 0 : miss + 1;
    end
    in_valid = 1'b0;
    checks++; failures++;
    $display("FAIL send_accept byte=%0h not accepted, required acceptance within 64 cycles", b);
  endtask

  task automatic exp_strobe(input int sel, input int addr, input logic [7:0] d);
    exp_sq.push_back('{we: NM'(1) << sel, addr: AW'(addr), data: d, cyc: 0});
  endtask

  task automatic verify_strobes(input string tag, input int gap);
    @(negedge clk); #1;
    check({tag, "_count"}, sq.size(), exp_sq.size());
    for (int i = 0; i < exp_sq.size() && i < sq.size(); i++) begin
      check({tag, "_we"}, sq[i].we, exp_sq[i].we);
      check({tag, "_addr"}, sq[i].addr, exp_sq[i].addr);
      check({tag, "_data"}, sq[i].data, exp_sq[i].data);
      if (gap > 0 && i > 0) check({tag, "_gap"}, sq[i].cyc - sq[i-1].cyc, gap);
    end
    sq.delete(); exp_sq.delete();
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_data = '0; conv_done = '0;
    @(negedge clk); reset = 1'b0; #1;
    tick(); reset = 1'b1; tick();
    sq.delete(); exp_sq.delete(); cq.delete();
  endtask

  task automatic check_op(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  typedef struct { logic [31:0] seq; int n; logic e; logic [1:0] code; logic bsy; logic rdy; } vec_t;
  vec_t vt[10];

  logic [7:0] sel, d, b;
  logic [15:0] len;
  int kind, k, dly, exp_err, exp_code, exp_bw;

  initial begin
    vt[0] = '{32'h55000000, 1, 1, 1, 0, 1};
    vt[1] = '{32'h20000000, 1, 1, 1, 0, 1};
    vt[2] = '{32'h24000000, 1, 1, 1, 0, 1};
    vt[3] = '{32'h19070000, 2, 1, 2, 0, 1};
    vt[4] = '{32'h19060000, 4, 0, 0, 0, 1};
    vt[5] = '{32'h19001100, 4, 1, 3, 0, 1};
    vt[6] = '{32'h19000001, 4, 1, 3, 0, 1};
    vt[7] = '{32'h19061000, 3, 0, 0, 1, 1};
    vt[8] = '{32'h23000000, 1, 0, 0, 1, 0};
    vt[9] = '{32'h19000000, 1, 0, 0, 1, 1};

    // reset values
    do_reset();
    check("rst_in_ready", in_ready, 1);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_data", mem_data, 0);
    check("rst_conv_start", conv_start, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_bw", bytes_written, 0);

    // back-to-back three-byte write
    send(8'h19, 0); send(8'h02, 0); send(8'h03, 0); send(8'h00, 0);
    check("wr3_busy_hdr", busy, 1);
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0);
    exp_strobe(2, 0, 8'hAA); exp_strobe(2, 1, 8'hBB); exp_strobe(2, 2, 8'hCC);
    verify_strobes("wr3", 1);
    check("wr3_bw", bytes_written, 3);
    check_op("wr3");

    // layer 1 start, foreign done ignored, own done after 10 cycles
    send(8'h22, 0);
    check("cv_in_ready", in_ready, 0);
    check("cv_busy", busy, 1);
    check("cv_start", conv_start, 3'b010);
    tick();
    check("cv_start_1cyc", conv_start, 0);
    conv_done = 3'b100; tick(); conv_done = '0;
    check("cv_foreign_done", busy, 1);
    repeat (9) tick();
    conv_done = 3'b010; tick(); conv_done = '0;
    check_op("cv_done");
    check("cv_pulses", cq.size(), 1);
    cq.delete();

    // bad opcode, then bad select
    send(8'h55, 0);
    check("badop_err", err, 1);
    check("badop_code", err_code, 1);
    check_op("badop");
    send(8'h19, 0); send(8'h09, 0);
    check("badsel_code", err_code, 2);
    check("badsel_err", err, 1);
    check_op("badsel");
    verify_strobes("badsel", 0);

    // length 17 overflows 4-bit address space; length 16 fills it exactly
    send(8'h19, 0); send(8'h00, 0); send(8'h11, 0); send(8'h00, 0);
    check("ovf_code", err_code, 3);
    check_op("ovf");
    send(8'h19, 0); send(8'h00, 0); send(8'h10, 0); send(8'h00, 0);
    for (int i = 0; i < 16; i++) begin
      send(8'(8'h40 + i), 0);
      exp_strobe(0, i, 8'(8'h40 + i));
    end
    verify_strobes("full16", 1);
    check("full16_bw", bytes_written, 16);
    check_op("full16");

    // payload with valid on alternate cycles
    send(8'h19, 0); send(8'h03, 0); send(8'h04, 0); send(8'h00, 0);
    for (int i = 0; i < 4; i++) begin
      send(8'(8'h90 + i), 2);
      exp_strobe(3, i, 8'(8'h90 + i));
    end
    verify_strobes("toggle", 2);
    check("toggle_bw", bytes_written, 4);

    // asynchronous reset in the middle of a payload
    @(posedge clk); #1;
    send(8'h19, 0); send(8'h01, 0); send(8'h08, 0); send(8'h00, 0);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
    check("mid_live_we", mem_we, 7'b0000010);
    in_valid = 1'b1; in_data = 8'h77;
    #2; reset = 1'b0; #1;
    check("mid_rst_we", mem_we, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_code", err_code, 0);
    check("mid_rst_bw", bytes_written, 0);
    check_op("mid_rst");
    in_valid = 1'b0;
    tick(); reset = 1'b1; tick();
    sq.delete(); cq.delete();
    send(8'h21, 0);
    check("mid_after_start", conv_start, 3'b001);
    tick(); conv_done = 3'b001; tick(); conv_done = '0;
    check_op("mid_after_done");
    cq.delete();

    // vector table, each from a fresh reset
    for (int v = 0; v < 10; v++) begin
      do_reset();
      for (int i = 0; i < vt[v].n; i++) begin
        b = vt[v].seq[31 - 8*i -: 8];
        send(b, 0);
      end
      check($sformatf("vec%0d_err", v), err, vt[v].e);
      check($sformatf("vec%0d_code", v), err_code, vt[v].code);
      check($sformatf("vec%0d_busy", v), busy, vt[v].bsy);
      check($sformatf("vec%0d_rdy", v), in_ready, vt[v].rdy);
      check($sformatf("vec%0d_we", v), mem_we, 0);
    end

`ifdef CONV_CTRL_TIMEOUT_EN
    // stalled payload times out after TIMEOUT_CYC idle cycles
    do_reset();
    send(8'h19, 0); send(8'h00, 0); send(8'h04, 0); send(8'h00, 0); send(8'hAA, 0);
    exp_strobe(0, 0, 8'hAA);
    repeat (TO - 1) tick();
    check("to_pending_busy", busy, 1);
    check("to_pending_err", err, 0);
    tick();
    check("to_err", err, 1);
    check("to_code", err_code, 3);
    check_op("to");
    verify_strobes("to", 0);
    send(8'h21, 0);
    check("to_next_start", conv_start, 3'b001);
    tick(); conv_done = 3'b001; tick(); conv_done = '0;
    cq.delete();
`endif

    // random command stream against a transaction-level model
    do_reset();
    exp_err = 0; exp_code = 0; exp_bw = 0;
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 4) begin
        sel = 8'($urandom_range(0, NM - 1));
        len = 16'($urandom_range(0, 16));
        if ($urandom_range(0, 3) == 0) len = 16'd16;
        send(8'h19, 1); send(sel, 1); send(len[7:0], 1); send(len[15:8], 1);
        for (int i = 0; i < int'(len); i++) begin
          d = 8'($urandom);
          send(d, 1);
          exp_strobe(int'(sel), i, d);
        end
        exp_bw = int'(len);
      end else if (kind == 5) begin
        sel = 8'($urandom_range(NM, 255));
        send(8'h19, 1); send(sel, 1);
        exp_err = 1; exp_code = 2;
      end else if (kind == 6) begin
        len = 16'($urandom_range(17, 65535));
        send(8'h19, 1); send(8'($urandom_range(0, NM - 1)), 1); send(len[7:0], 1); send(len[15:8], 1);
        exp_err = 1; exp_code = 3;
      end else if (kind == 7) begin
        do b = 8'($urandom_range(0, 255));
        while (b == 8'h19 || (b >= 8'h21 && b <= 8'h23));
        send(b, 1);
        exp_err = 1; exp_code = 1;
      end else begin
        k = $urandom_range(0, NC - 1);
        send(8'(8'h21 + k), 1);
        check("rnd_cv_busy", busy, 1);
        check("rnd_cv_rdy", in_ready, 0);
        dly = $urandom_range(1, 5);
        for (int j = 0; j < dly; j++) begin
          in_valid = 1'b1; in_data = 8'($urandom);
          conv_done = NC'($urandom) & ~(NC'(1) << k);
          tick();
        end
        in_valid = 1'b0;
        conv_done = NC'(1) << k; tick(); conv_done = '0;
        check("rnd_cv_pulses", cq.size(), 1);
        if (cq.size() > 0) check("rnd_cv_layer", cq[0], NC'(1) << k);
        cq.delete();
      end
      verify_strobes("rnd", 0);
      check("rnd_err", err, exp_err);
      check("rnd_code", err_code, exp_code);
      check("rnd_bw", bytes_written, exp_bw);
      check_op("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
